// File: rtl/alu_chan_scheduler.sv
// Shares one FIR ALU between the left and right channels: each sample runs left
// then right, latches each result and flags dropped requests or stalled computations.
module alu_chan_scheduler #(
    parameter int DW      = 40,
    parameter int TMO_W   = 12,
    parameter int TMO_MAX = 4000
) (
    input  logic          Sclk,
    input  logic          uni_reset_n,
    input  logic          ALU_calc,
    input  logic          alu_finish,
    input  logic [DW-1:0] alu_out,
    output logic          alu_start,
    output logic          chan_sel,
    output logic          ALU_finish_L,
    output logic          ALU_finish_R,
    output logic [DW-1:0] ALU_out_L,
    output logic [DW-1:0] ALU_out_R,
    output logic          busy,
    output logic          overrun,
    output logic          timeout
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START_L = 3'd1;
    localparam logic [2:0] S_WAIT_L  = 3'd2;
    localparam logic [2:0] S_START_R = 3'd3;
    localparam logic [2:0] S_WAIT_R  = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [TMO_W-1:0] WDOG_LAST = TMO_W'(TMO_MAX - 1);

    logic [2:0]       state_q, state_d;
    logic             pend_q, pend_d;
    logic [TMO_W-1:0] wdog_q, wdog_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;
    logic             finL_q, finL_d;
    logic             finR_q, finR_d;
    logic [DW-1:0]    outL_q, outL_d;
    logic [DW-1:0]    outR_q, outR_d;
    logic             inFlight;
    logic             wdogExpired;

    assign inFlight    = (state_q == S_START_L) || (state_q == S_WAIT_L) ||
                         (state_q == S_START_R) || (state_q == S_WAIT_R);
    assign wdogExpired = (wdog_q == WDOG_LAST);

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        wdog_d    = wdog_q;
        overrun_d = overrun_q;
        timeout_d = timeout_q;
        finL_d    = 1'b0;
        finR_d    = 1'b0;
        outL_d    = outL_q;
        outR_d    = outR_q;

        // Only one request can wait behind the running sample; any further one is lost.
        if (ALU_calc && inFlight) begin
            if (pend_q) begin
                overrun_d = 1'b1;
            end else begin
                pend_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (ALU_calc || pend_q) begin
                    state_d = S_START_L;
                    pend_d  = 1'b0;
                end
            end
            S_START_L: begin
                wdog_d  = '0;
                state_d = S_WAIT_L;
            end
            S_WAIT_L: begin
                wdog_d = wdog_q + TMO_W'(1);
                if (alu_finish) begin
                    outL_d  = alu_out;
                    finL_d  = 1'b1;
                    state_d = S_START_R;
                end else if (wdogExpired) begin
                    outL_d    = '0;
                    finL_d    = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = S_START_R;
                end
            end
            S_START_R: begin
                wdog_d  = '0;
                state_d = S_WAIT_R;
            end
            S_WAIT_R: begin
                wdog_d = wdog_q + TMO_W'(1);
                if (alu_finish) begin
                    outR_d  = alu_out;
                    finR_d  = 1'b1;
                    state_d = S_DONE;
                end else if (wdogExpired) begin
                    outR_d    = '0;
                    finR_d    = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                // Serving the queued request while a fresh one arrives keeps the fresh one queued.
                if (pend_q) begin
                    state_d = S_START_L;
                    pend_d  = ALU_calc;
                end else if (ALU_calc) begin
                    state_d = S_START_L;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Sclk or negedge uni_reset_n) begin
        if (!uni_reset_n) begin
            state_q   <= S_IDLE;
            pend_q    <= 1'b0;
            wdog_q    <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            finL_q    <= 1'b0;
            finR_q    <= 1'b0;
            outL_q    <= '0;
            outR_q    <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            wdog_q    <= wdog_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            finL_q    <= finL_d;
            finR_q    <= finR_d;
            outL_q    <= outL_d;
            outR_q    <= outR_d;
        end
    end

    assign alu_start    = (state_q == S_START_L) || (state_q == S_START_R);
    assign chan_sel     = (state_q == S_START_R) || (state_q == S_WAIT_R);
    assign busy         = (state_q != S_IDLE);
    assign ALU_finish_L = finL_q;
    assign ALU_finish_R = finR_q;
    assign ALU_out_L    = outL_q;
    assign ALU_out_R    = outR_q;
    assign overrun      = overrun_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_alu_chan_scheduler.sv
// Directed bench for alu_chan_scheduler: the bench plays the shared ALU and the
// main control FSM, with every expected value worked out by hand.
module tb_alu_chan_scheduler;

    logic        Sclk;
    logic        uni_reset_n;
    logic        ALU_calc;
    logic        alu_finish;
    logic [39:0] alu_out;
    logic        alu_start;
    logic        chan_sel;
    logic        ALU_finish_L;
    logic        ALU_finish_R;
    logic [39:0] ALU_out_L;
    logic [39:0] ALU_out_R;
    logic        busy;
    logic        overrun;
    logic        timeout;

    int nChecks = 0;
    int nBad    = 0;

    alu_chan_scheduler #(
        .DW      (40),
        .TMO_W   (12),
        .TMO_MAX (16)
    ) dut (
        .Sclk         (Sclk),
        .uni_reset_n  (uni_reset_n),
        .ALU_calc     (ALU_calc),
        .alu_finish   (alu_finish),
        .alu_out      (alu_out),
        .alu_start    (alu_start),
        .chan_sel     (chan_sel),
        .ALU_finish_L (ALU_finish_L),
        .ALU_finish_R (ALU_finish_R),
        .ALU_out_L    (ALU_out_L),
        .ALU_out_R    (ALU_out_R),
        .busy         (busy),
        .overrun      (overrun),
        .timeout      (timeout)
    );

    // 10-unit clock; the bench drives and samples on the falling edge
    initial Sclk = 1'b0;
    always #5 Sclk = ~Sclk;

    task automatic checkOutput(input string tag, input logic [39:0] observed, input logic [39:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nBad++;
            $display("[TB] FAIL %s: got %h want %h", tag, observed, expected);
        end
    endtask

    // Kick off one sample; returns at the falling edge inside START_L
    task automatic applyStimulus();
        ALU_calc = 1'b1;
        @(negedge Sclk);
        ALU_calc = 1'b0;
        checkOutput("busyOnStart", 40'(busy), 40'd1);
    endtask

    // Entered at the falling edge inside START_x; the ALU answers (or not) in WAIT cycle 'delay'
    // and nCalc extra requests arrive on WAIT cycles 1,3,5...; returns inside the following state
    task automatic runChannel(input bit right, input logic [39:0] val, input int delay,
                              input bit respond, input int nCalc,
                              input logic [39:0] expOut, input bit expTmo);
        checkOutput(right ? "startR" : "startL", 40'(alu_start), 40'd1);
        checkOutput(right ? "selR" : "selL", 40'(chan_sel), 40'(right));
        for (int k = 1; k <= delay; k++) begin
            @(negedge Sclk);
            ALU_calc = (k <= 2 * nCalc) && (k % 2 == 1);
        end
        if (respond) begin
            alu_finish = 1'b1;
            alu_out    = val;
        end
        @(negedge Sclk);
        alu_finish = 1'b0;
        ALU_calc   = 1'b0;
        alu_out    = '0;
        checkOutput(right ? "finR" : "finL", 40'(right ? ALU_finish_R : ALU_finish_L), 40'd1);
        checkOutput(right ? "outR" : "outL", right ? ALU_out_R : ALU_out_L, expOut);
        checkOutput("timeout", 40'(timeout), 40'(expTmo));
    endtask

    // Entered inside DONE; expNext=1 means a queued sample must start with no idle cycle
    task automatic afterDone(input bit expNext);
        checkOutput("doneSel", 40'(chan_sel), 40'd0);
        checkOutput("doneBusy", 40'(busy), 40'd1);
        checkOutput("doneStart", 40'(alu_start), 40'd0);
        @(negedge Sclk);
        checkOutput("nextBusy", 40'(busy), 40'(expNext));
        checkOutput("nextStart", 40'(alu_start), 40'(expNext));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation ran past its time budget");
        $fatal(1, "[TB] time budget exceeded");
    end

    initial begin
        uni_reset_n = 1'b0;
        ALU_calc    = 1'b0;
        alu_finish  = 1'b0;
        alu_out     = '0;

        // reset state
        #1;
        checkOutput("rstStart", 40'(alu_start), 40'd0);
        checkOutput("rstSel", 40'(chan_sel), 40'd0);
        checkOutput("rstBusy", 40'(busy), 40'd0);
        checkOutput("rstOutL", ALU_out_L, 40'd0);
        checkOutput("rstOutR", ALU_out_R, 40'd0);
        checkOutput("rstOverrun", 40'(overrun), 40'd0);
        checkOutput("rstTimeout", 40'(timeout), 40'd0);
        @(negedge Sclk);
        uni_reset_n = 1'b1;
        @(negedge Sclk);
        checkOutput("idleBusy", 40'(busy), 40'd0);

        $display("[TB] single sample");
        applyStimulus();
        runChannel(1'b0, 40'h00_0000_1234, 10, 1'b1, 0, 40'h00_0000_1234, 1'b0);
        runChannel(1'b1, 40'hFF_FFFF_FFF0, 10, 1'b1, 0, 40'hFF_FFFF_FFF0, 1'b0);
        afterDone(1'b0);

        $display("[TB] spurious finish in idle");
        alu_finish = 1'b1;
        alu_out    = 40'h00_DEAD_BEEF;
        @(negedge Sclk);
        alu_finish = 1'b0;
        alu_out    = '0;
        @(negedge Sclk);
        checkOutput("spurFinL", 40'(ALU_finish_L), 40'd0);
        checkOutput("spurFinR", 40'(ALU_finish_R), 40'd0);
        checkOutput("spurOutL", ALU_out_L, 40'h00_0000_1234);
        checkOutput("spurOutR", ALU_out_R, 40'hFF_FFFF_FFF0);
        checkOutput("spurBusy", 40'(busy), 40'd0);
        checkOutput("spurStart", 40'(alu_start), 40'd0);

        $display("[TB] queued request");
        applyStimulus();
        runChannel(1'b0, 40'h01_0000_0001, 10, 1'b1, 1, 40'h01_0000_0001, 1'b0);
        runChannel(1'b1, 40'h02_0000_0002, 6, 1'b1, 0, 40'h02_0000_0002, 1'b0);
        afterDone(1'b1);
        runChannel(1'b0, 40'h03_0000_0003, 4, 1'b1, 0, 40'h03_0000_0003, 1'b0);
        runChannel(1'b1, 40'h04_0000_0004, 4, 1'b1, 0, 40'h04_0000_0004, 1'b0);
        checkOutput("queueOverrun", 40'(overrun), 40'd0);
        afterDone(1'b0);

        $display("[TB] finish on the last watchdog cycle");
        applyStimulus();
        runChannel(1'b0, 40'h12_3456_789A, 16, 1'b1, 0, 40'h12_3456_789A, 1'b0);
        runChannel(1'b1, 40'h80_0000_0000, 16, 1'b1, 0, 40'h80_0000_0000, 1'b0);
        afterDone(1'b0);

        $display("[TB] overrun");
        applyStimulus();
        runChannel(1'b0, 40'h00_0000_0011, 10, 1'b1, 3, 40'h00_0000_0011, 1'b0);
        checkOutput("overrunSet", 40'(overrun), 40'd1);
        runChannel(1'b1, 40'h00_0000_0022, 3, 1'b1, 0, 40'h00_0000_0022, 1'b0);
        afterDone(1'b1);
        runChannel(1'b0, 40'h00_0000_0033, 3, 1'b1, 0, 40'h00_0000_0033, 1'b0);
        runChannel(1'b1, 40'h00_0000_0044, 3, 1'b1, 0, 40'h00_0000_0044, 1'b0);
        afterDone(1'b0);
        @(negedge Sclk);
        checkOutput("onlyTwoSeq", 40'(busy), 40'd0);

        $display("[TB] left channel timeout");
        applyStimulus();
        runChannel(1'b0, 40'h77_7777_7777, 16, 1'b0, 0, 40'd0, 1'b1);
        runChannel(1'b1, 40'h55_AAAA_0001, 5, 1'b1, 0, 40'h55_AAAA_0001, 1'b1);
        afterDone(1'b0);

        $display("[TB] async reset in WAIT_R");
        applyStimulus();
        runChannel(1'b0, 40'h0A_0B0C_0D0E, 4, 1'b1, 0, 40'h0A_0B0C_0D0E, 1'b1);
        checkOutput("preRstStart", 40'(alu_start), 40'd1);
        @(negedge Sclk);
        ALU_calc = 1'b1;
        @(negedge Sclk);
        ALU_calc = 1'b0;
        @(negedge Sclk);
        checkOutput("preRstSel", 40'(chan_sel), 40'd1);
        #2;
        uni_reset_n = 1'b0;
        #1;
        checkOutput("arstSel", 40'(chan_sel), 40'd0);
        checkOutput("arstBusy", 40'(busy), 40'd0);
        checkOutput("arstStart", 40'(alu_start), 40'd0);
        checkOutput("arstOutL", ALU_out_L, 40'd0);
        checkOutput("arstOutR", ALU_out_R, 40'd0);
        checkOutput("arstFinL", 40'(ALU_finish_L), 40'd0);
        checkOutput("arstTimeout", 40'(timeout), 40'd0);
        checkOutput("arstOverrun", 40'(overrun), 40'd0);
        @(negedge Sclk);
        uni_reset_n = 1'b1;
        @(negedge Sclk);
        @(negedge Sclk);
        checkOutput("postRstBusy", 40'(busy), 40'd0);
        checkOutput("postRstStart", 40'(alu_start), 40'd0);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
